nor_reduce_pipe: RTL and testbench

- Parametrised successor to the 2-input NOR cell: a WIDTH-input reduction NOR/OR/AND/NAND unit.
- The function is built as a tree of FANIN-input gate groups, matching the fan-in limit of the discrete-transistor cells.
- Output is registered through STAGES pipeline registers with valid/ready flow control.
- Counts true results in a saturating counter.
- Used by the RV523 datapath for branch zero-detect (A==0) and all-ones checks.

---
 rtl/nor_reduce_pipe.sv | 205 ++++++++++++++++++++
 tb/tb_nor_reduce_pipe.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nor_reduce_pipe.sv
// nor_reduce_pipe: WIDTH-input reduction NOR/AND/OR/NAND built from a tree
// of FANIN-input gate groups, followed by a STAGES-deep valid/ready pipeline
// and a saturating count of consumed results that evaluate true.
//
// MODE encoding: 00 NOR (zero detect), 01 AND (all ones),
//                10 OR (any one),      11 NAND (any zero).
// MODE[0] selects the group operator (1: AND, 0: OR) and therefore the pad
// value. The final inversion (NOR/NAND) is applied at the output from the
// mode carried along with the word, so an in-flight word is always finished
// with the mode it was accepted with.
module nor_reduce_pipe #(
   parameter int WIDTH  = 32,
   parameter int FANIN  = 2,
   parameter int STAGES = 1,
   parameter int CNT_W  = 8
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             A_VALID,
   output logic             A_READY,
   input  logic [WIDTH-1:0] A,
   input  logic [1:0]       MODE,
   output logic             Y_VALID,
   input  logic             Y_READY,
   output logic             Y,
   input  logic             CNT_CLR,
   output logic [CNT_W-1:0] CNT
);

   // Number of tree levels needed so that FANIN^levels >= WIDTH (at least one,
   // so a one-bit input still passes through a padded gate group).
   function automatic int tree_levels(input int w, input int f);
      int span;
      int lv;
      span = 1;
      lv   = 0;
      while (span < w) begin
         span = span * f;
         lv   = lv + 1;
      end
      if (lv == 0) begin
         lv = 1;
      end
      return lv;
   endfunction

   // Integer power used to size each tree level.
   function automatic int ipow(input int b, input int e);
      int r;
      r = 1;
      for (int i = 0; i < e; i++) begin
         r = r * b;
      end
      return r;
   endfunction

   // One FANIN-wide gate group: AND when and_sel, otherwise OR.
   function automatic logic grp_reduce(input logic [FANIN-1:0] grp, input logic and_sel);
      return and_sel ? (&grp) : (|grp);
   endfunction

   // NOR (00) and NAND (11) invert the raw OR/AND tree output.
   function automatic logic mode_inverts(input logic [1:0] m);
      return (m[1] == m[0]);
   endfunction

   // Saturating increment for the true-result counter.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      logic [CNT_W-1:0] v_max;
      v_max = '1;
      return (v == v_max) ? v : (v + 1'b1);
   endfunction

   localparam int LEVELS = tree_levels(WIDTH, FANIN);
   localparam int PAD_W  = ipow(FANIN, LEVELS);

   // Elaboration-time guard on the supported parameter ranges.
   if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
      $error("nor_reduce_pipe: WIDTH must be 1..64");
   end
   if (FANIN < 2 || FANIN > 4) begin : g_bad_fanin
      $error("nor_reduce_pipe: FANIN must be 2..4");
   end
   if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
      $error("nor_reduce_pipe: STAGES must be 1..4");
   end
   if (CNT_W < 1 || CNT_W > 16) begin : g_bad_cntw
      $error("nor_reduce_pipe: CNT_W must be 1..16");
   end

   // ---------------------------------------------------------------------
   // Reduction tree (combinational, in front of stage 0)
   // ---------------------------------------------------------------------
   logic             w_and_sel;
   logic [PAD_W-1:0] w_lvl0;
   logic             w_raw;

   assign w_and_sel = MODE[0];

   // Pad the unused leaf inputs with the identity of the selected operator.
   always_comb begin
      w_lvl0              = {PAD_W{w_and_sel}};
      w_lvl0[WIDTH-1:0]   = A;
   end

   for (genvar lv = 0; lv < LEVELS; lv++) begin : g_lvl
      localparam int N_IN  = PAD_W / ipow(FANIN, lv);
      localparam int N_OUT = N_IN / FANIN;

      logic [N_IN-1:0]  w_in;
      logic [N_OUT-1:0] w_out;

      if (lv == 0) begin : g_leaf
         assign w_in = w_lvl0;
      end else begin : g_inner
         assign w_in = g_lvl[lv-1].w_out;
      end

      // Collapse each FANIN-wide group of this level into one node.
      always_comb begin
         w_out = '0;
         for (int g = 0; g < N_OUT; g++) begin
            w_out[g] = grp_reduce(w_in[g*FANIN +: FANIN], w_and_sel);
         end
      end
   end

   assign w_raw = g_lvl[LEVELS-1].w_out[0];

   // ---------------------------------------------------------------------
   // Pipeline stages with bubble-collapsing valid/ready
   // ---------------------------------------------------------------------
   for (genvar k = 0; k < STAGES; k++) begin : g_stg
      logic       r_vld;
      logic       r_raw;
      logic [1:0] r_mode;
      logic       w_up_vld;
      logic       w_up_raw;
      logic [1:0] w_up_mode;
      logic       w_adv;
      logic       w_ld;

      if (k == 0) begin : g_head
         assign w_up_vld  = A_VALID;
         assign w_up_raw  = w_raw;
         assign w_up_mode = MODE;
      end else begin : g_link
         assign w_up_vld  = g_stg[k-1].r_vld;
         assign w_up_raw  = g_stg[k-1].r_raw;
         assign w_up_mode = g_stg[k-1].r_mode;
      end

      if (k == STAGES - 1) begin : g_tail
         assign w_adv = r_vld & Y_READY;
      end else begin : g_mid
         assign w_adv = r_vld & g_stg[k+1].w_ld;
      end

      // A stage can take a new word when it is empty or its word moves on.
      assign w_ld = ~r_vld | w_adv;

      // Stage occupancy: the only pipeline state that reset touches.
      always_ff @(posedge CLK) begin
         if (!RST_N) begin
            r_vld <= 1'b0;
         end else if (w_ld) begin
            r_vld <= w_up_vld;
         end
      end

      // Stage payload: raw tree result and the mode it was accepted with.
      always_ff @(posedge CLK) begin
         if (w_ld && w_up_vld) begin
            r_raw  <= w_up_raw;
            r_mode <= w_up_mode;
         end
      end
   end

   assign A_READY = g_stg[0].w_ld;
   assign Y_VALID = g_stg[STAGES-1].r_vld;
   assign Y       = Y_VALID & (g_stg[STAGES-1].r_raw ^ mode_inverts(g_stg[STAGES-1].r_mode));

   // ---------------------------------------------------------------------
   // True-result counter
   // ---------------------------------------------------------------------
   logic [CNT_W-1:0] r_cnt;
   logic             w_hit;

   assign w_hit = Y_VALID & Y_READY & Y;

   // Count consumed true results; clear wins over a same-cycle increment.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_cnt <= '0;
      end else if (CNT_CLR) begin
         r_cnt <= '0;
      end else if (w_hit) begin
         r_cnt <= sat_inc(r_cnt);
      end
   end

   assign CNT = r_cnt;

endmodule

// File: tb/tb_nor_reduce_pipe.sv
// Testbench for nor_reduce_pipe: several parameter corners side by side,
// each with its own scoreboard queue and counter model, plus directed
// sequences for latency, mode sweep, backpressure, counter and reset.
module tb_nor_reduce_pipe;

   localparam int NI = 7;
   localparam int W_T [NI] = '{32, 5, 64, 1, 7, 64, 1};
   localparam int F_T [NI] = '{ 2, 2,  4, 2, 3,  3, 4};
   localparam int S_T [NI] = '{ 1, 3,  2, 1, 4,  4, 4};
   localparam int C_T [NI] = '{ 8, 2,  8, 4, 3, 16, 1};

   logic        clk = 1'b0;
   logic        rstn [NI];
   logic        av   [NI];
   logic        ar   [NI];
   logic [63:0] a    [NI];
   logic [1:0]  mode [NI];
   logic        yv   [NI];
   logic        yr   [NI];
   logic        y    [NI];
   logic        clr  [NI];
   logic [15:0] cnt  [NI];

   bit chk_en     = 1'b0;
   bit drain_done = 1'b0;
   int n_tests    = 0;
   int n_fail     = 0;

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference reduction over the low w bits.
   function automatic logic ref_y(input logic [63:0] v, input int w, input logic [1:0] m);
      logic any1;
      logic all1;
      any1 = 1'b0;
      all1 = 1'b1;
      for (int b = 0; b < w; b++) begin
         any1 = any1 | v[b];
         all1 = all1 & v[b];
      end
      case (m)
         2'b00:   return ~any1;
         2'b01:   return all1;
         2'b10:   return any1;
         default: return ~all1;
      endcase
   endfunction

   // Biased random operand: zeros, ones, one bit cleared, one bit set, random.
   function automatic logic [63:0] rnd_a(input int w);
      logic [63:0] r;
      int          k;
      k = int'($urandom_range(0, 32'(w - 1)));
      case ($urandom_range(0, 4))
         0: r = '0;
         1: r = '1;
         2: begin r = '1; r[k] = 1'b0; end
         3: begin r = '0; r[k] = 1'b1; end
         default: r = {$urandom, $urandom};
      endcase
      return r;
   endfunction

   for (genvar gi = 0; gi < NI; gi++) begin : g_inst
      localparam int W  = W_T[gi];
      localparam int CW = C_T[gi];
      localparam logic [15:0] CMAX = 16'((32'd1 << CW) - 1);

      logic [CW-1:0] w_cnt;
      logic          q [$];
      logic [15:0]   cm = '0;
      logic          e;

      nor_reduce_pipe #(
         .WIDTH (W),
         .FANIN (F_T[gi]),
         .STAGES(S_T[gi]),
         .CNT_W (CW)
      ) u_dut (
         .CLK    (clk),
         .RST_N  (rstn[gi]),
         .A_VALID(av[gi]),
         .A_READY(ar[gi]),
         .A      (a[gi][W-1:0]),
         .MODE   (mode[gi]),
         .Y_VALID(yv[gi]),
         .Y_READY(yr[gi]),
         .Y      (y[gi]),
         .CNT_CLR(clr[gi]),
         .CNT    (w_cnt)
      );

      assign cnt[gi] = 16'(w_cnt);

      // Scoreboard and counter model, sampled mid-cycle before each edge.
      always @(negedge clk) begin
         if (chk_en) begin
            chk($sformatf("u%0d cnt", gi), 64'(cnt[gi]), 64'(cm));
            if (!yv[gi]) chk($sformatf("u%0d idle_y", gi), 64'(y[gi]), 64'd0);
            if (!rstn[gi]) begin
               q.delete();
               cm = '0;
            end else begin
               if (yv[gi] && yr[gi]) begin
                  chk($sformatf("u%0d result_expected", gi), 64'(q.size() != 0), 64'd1);
                  if (q.size() != 0) begin
                     e = q.pop_front();
                     chk($sformatf("u%0d y", gi), 64'(y[gi]), 64'(e));
                     if (e && cm != CMAX) cm = cm + 16'd1;
                  end
               end
               if (clr[gi]) cm = '0;
               if (av[gi] && ar[gi]) q.push_back(ref_y(a[gi], W, mode[gi]));
            end
         end
      end

      initial begin
         wait (drain_done);
         chk($sformatf("u%0d drained", gi), 64'(q.size()), 64'd0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [4:0] pat   [3];
   logic [3:0] exp_t [3];
   logic [4:0] bw    [5];
   logic [1:0] bm    [5];
   logic       accq  [$];
   int         acc;
   int         nw;

   initial begin
      pat   = '{5'b11111, 5'b01111, 5'b00000};
      exp_t = '{4'b0110, 4'b1100, 4'b1001};   // {NAND,OR,AND,NOR}
      bw    = '{5'b00000, 5'b10000, 5'b11111, 5'b00001, 5'b11110};
      bm    = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd3};

      for (int i = 0; i < NI; i++) begin
         rstn[i] = 1'b0; av[i] = 1'b0; yr[i] = 1'b0; clr[i] = 1'b0;
         a[i] = '0; mode[i] = 2'd0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) rstn[i] = 1'b1;
      chk_en = 1'b1;
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("u%0d rst_a_ready", i), 64'(ar[i]), 64'd1);
         chk($sformatf("u%0d rst_y_valid", i), 64'(yv[i]), 64'd0);
         chk($sformatf("u%0d rst_cnt", i), 64'(cnt[i]), 64'd0);
      end

      // Zero detect, STAGES=1
      yr[0] = 1'b1; av[0] = 1'b1; a[0] = '0; mode[0] = 2'b00;
      tick();
      chk("t1 vld0", 64'(yv[0]), 64'd1);
      chk("t1 y0", 64'(y[0]), 64'd1);
      a[0] = 64'h400;
      tick();
      chk("t1 vld1", 64'(yv[0]), 64'd1);
      chk("t1 y1", 64'(y[0]), 64'd0);
      av[0] = 1'b0;
      tick();
      chk("t1 vld_idle", 64'(yv[0]), 64'd0);
      chk("t1 cnt", 64'(cnt[0]), 64'd1);

      // Mode sweep with padding, WIDTH=5, STAGES=3
      yr[1] = 1'b1;
      for (int p = 0; p < 3; p++) begin
         for (int m = 0; m < 4; m++) begin
            a[1] = 64'(pat[p]); mode[1] = 2'(m); av[1] = 1'b1;
            tick();
            av[1] = 1'b0; mode[1] = ~2'(m); a[1] = '1;
            tick();
            chk($sformatf("t2 early p%0d m%0d", p, m), 64'(yv[1]), 64'd0);
            tick();
            chk($sformatf("t2 vld p%0d m%0d", p, m), 64'(yv[1]), 64'd1);
            chk($sformatf("t2 y p%0d m%0d", p, m), 64'(y[1]), 64'(exp_t[p][m]));
            tick();
         end
      end

      // Backpressure, STAGES=3
      yr[1] = 1'b0; acc = 0;
      for (int j = 0; j < 5; j++) begin
         a[1] = 64'(bw[j]); mode[1] = bm[j]; av[1] = 1'b1;
         if (ar[1]) begin
            accq.push_back(ref_y(64'(bw[j]), 5, bm[j]));
            acc++;
         end
         tick();
      end
      av[1] = 1'b0;
      chk("t3 accepted", 64'(acc), 64'd3);
      chk("t3 full_ready", 64'(ar[1]), 64'd0);
      yr[1] = 1'b1;
      #1;
      chk("t3 ready_on_drain", 64'(ar[1]), 64'd1);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("t3 vld%0d", k), 64'(yv[1]), 64'd1);
         if (accq.size() != 0) chk($sformatf("t3 y%0d", k), 64'(y[1]), 64'(accq.pop_front()));
         tick();
      end
      chk("t3 empty", 64'(yv[1]), 64'd0);

      // Counter saturation and clear priority, CNT_W=2
      clr[1] = 1'b1;
      tick();
      clr[1] = 1'b0;
      chk("t4 clr", 64'(cnt[1]), 64'd0);
      yr[1] = 1'b1; a[1] = '0; mode[1] = 2'b00; av[1] = 1'b1;
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("t4 stream_ready%0d", k), 64'(ar[1]), 64'd1);
         tick();
      end
      av[1] = 1'b0;
      repeat (4) tick();
      chk("t4 saturated", 64'(cnt[1]), 64'd3);
      yr[1] = 1'b0; av[1] = 1'b1;
      tick();
      av[1] = 1'b0;
      nw = 0;
      while (!yv[1] && nw < 10) begin
         tick();
         nw++;
      end
      chk("t4 wait_result", 64'(yv[1]), 64'd1);
      chk("t4 result_true", 64'(y[1]), 64'd1);
      clr[1] = 1'b1; yr[1] = 1'b1;
      tick();
      clr[1] = 1'b0;
      chk("t4 clr_priority", 64'(cnt[1]), 64'd0);

      // Reset mid-stream, STAGES=2
      yr[2] = 1'b1; a[2] = '0; mode[2] = 2'b00; av[2] = 1'b1;
      tick();
      av[2] = 1'b0;
      repeat (3) tick();
      chk("t5 cnt_before", 64'(cnt[2]), 64'd1);
      yr[2] = 1'b0; av[2] = 1'b1; a[2] = '0; mode[2] = 2'b00;
      tick();
      a[2] = 64'h1; mode[2] = 2'b10;
      tick();
      av[2] = 1'b0;
      chk("t5 full", 64'(ar[2]), 64'd0);
      chk("t5 held", 64'(yv[2]), 64'd1);
      rstn[2] = 1'b0;
      tick();
      rstn[2] = 1'b1;
      chk("t5 rst_vld", 64'(yv[2]), 64'd0);
      chk("t5 rst_y", 64'(y[2]), 64'd0);
      chk("t5 rst_cnt", 64'(cnt[2]), 64'd0);
      chk("t5 rst_ready", 64'(ar[2]), 64'd1);
      yr[2] = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk($sformatf("t5 no_stale%0d", k), 64'(yv[2]), 64'd0);
      end

      // Random traffic on every instance
      for (int cyc = 0; cyc < 10000; cyc++) begin
         for (int i = 0; i < NI; i++) begin
            av[i]   = ($urandom_range(0, 9) < 7);
            yr[i]   = ($urandom_range(0, 9) < 6);
            clr[i]  = ($urandom_range(0, 99) < 3);
            mode[i] = 2'($urandom_range(0, 3));
            a[i]    = rnd_a(W_T[i]);
         end
         tick();
      end
      for (int i = 0; i < NI; i++) begin
         av[i] = 1'b0; yr[i] = 1'b1; clr[i] = 1'b0;
      end
      repeat (12) tick();
      drain_done = 1'b1;
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
